// File: rtl/imem_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg
// Shared definitions for the instruction-fetch slice in front of the imem32
// word-addressed instruction ROM.
//   DEF_ADDR_WIDTH   : ROM word-address width (PC is two bits wider)
//   DEF_INSTR_LENGTH : instruction width, fixed at 32
//   NOP_INSTR        : canonical RV32 NOP (addi x0, x0, 0)
//   EBREAK_INSTR     : RV32 EBREAK encoding, used by the optional halt feature
//   fetch_state_t    : fetch sequencer states
//   fetch_entry_t    : one buffered fetch result {pc, instr}
// -----------------------------------------------------------------------------
package imem_pkg;

  localparam int DEF_ADDR_WIDTH   = 5;
  localparam int DEF_INSTR_LENGTH = 32;

  localparam logic [DEF_INSTR_LENGTH-1:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [DEF_INSTR_LENGTH-1:0] EBREAK_INSTR = 32'h0010_0073;

  // HALT is only ever entered when the EBREAK-halt feature is compiled in.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [DEF_ADDR_WIDTH+1:0]   pc;
    logic [DEF_INSTR_LENGTH-1:0] instr;
  } fetch_entry_t;

endpackage : imem_pkg

// File: rtl/imem_fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// imem_fetch_ctrl_if
// Bundles the ROM port, the execute redirect port and the decode handshake of
// the fetch sequencer.
//   imem_addr      : ROM word address            (controller -> ROM)
//   imem_instr     : ROM read data, combinational (ROM -> controller)
//   redirect_valid : one-cycle redirect pulse     (execute -> controller)
//   redirect_pc    : redirect target byte address (execute -> controller)
//   out_valid      : buffer head valid            (controller -> decode)
//   out_ready      : decode accepts head          (decode -> controller)
//   out_pc         : byte PC of head              (controller -> decode)
//   out_instr      : head instruction             (controller -> decode)
// Modports: master = fetch controller side, slave = ROM/execute/decode side.
// -----------------------------------------------------------------------------
interface imem_fetch_ctrl_if #(
  parameter int ADDR_WIDTH   = imem_pkg::DEF_ADDR_WIDTH,
  parameter int INSTR_LENGTH = imem_pkg::DEF_INSTR_LENGTH
);

  logic [ADDR_WIDTH-1:0]   imem_addr;
  logic [INSTR_LENGTH-1:0] imem_instr;
  logic                    redirect_valid;
  logic [ADDR_WIDTH+1:0]   redirect_pc;
  logic                    out_valid;
  logic                    out_ready;
  logic [ADDR_WIDTH+1:0]   out_pc;
  logic [INSTR_LENGTH-1:0] out_instr;

  modport master (
    output imem_addr,
    input  imem_instr,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_pc,
    output out_instr
  );

  modport slave (
    input  imem_addr,
    output imem_instr,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_pc,
    input  out_instr
  );

endinterface : imem_fetch_ctrl_if

// File: rtl/imem_fetch_ctrl_buf2.sv
// -----------------------------------------------------------------------------
// fetch_buf2
// Two-entry FIFO of fetch_entry_t. Entries shift toward slot 0 so the head is
// always a register and the decode outputs come straight from flops.
//   clk, rst   : clock, synchronous active-high reset (clears all contents)
//   flush      : drop all entries; overrides push and pop
//   push       : write push_entry at the tail (ignored when full without pop)
//   pop        : remove the head (ignored when empty)
//   push_entry : entry to write
//   count      : number of valid entries (0..2)
//   head_valid : registered count != 0
//   head       : oldest entry
// -----------------------------------------------------------------------------
module fetch_buf2
  import imem_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t push_entry,
  output logic [1:0]   count,
  output logic         head_valid,
  output fetch_entry_t head
);

  fetch_entry_t entry0_r, entry1_r;
  fetch_entry_t entry0_next_s, entry1_next_s;
  logic [1:0]   count_r, count_next_s;
  logic         valid_r;
  logic         do_push_s, do_pop_s;

  // Next-state of the shift FIFO: push-only, pop-only, or both at once.
  always_comb begin
    entry0_next_s = entry0_r;
    entry1_next_s = entry1_r;
    count_next_s  = count_r;
    do_pop_s      = pop && (count_r != 2'd0);
    do_push_s     = push && ((count_r != 2'd2) || do_pop_s);
    if (flush) begin
      count_next_s = 2'd0;
    end else begin
      case ({do_push_s, do_pop_s})
        2'b10: begin
          if (count_r == 2'd0) begin
            entry0_next_s = push_entry;
          end else begin
            entry1_next_s = push_entry;
          end
          count_next_s = count_r + 2'd1;
        end
        2'b01: begin
          entry0_next_s = entry1_r;
          count_next_s  = count_r - 2'd1;
        end
        2'b11: begin
          // Head leaves while the new entry arrives; count is unchanged.
          if (count_r == 2'd1) begin
            entry0_next_s = push_entry;
          end else begin
            entry0_next_s = entry1_r;
            entry1_next_s = push_entry;
          end
          count_next_s = count_r;
        end
        default: begin
          count_next_s = count_r;
        end
      endcase
    end
  end

  // FIFO storage, occupancy and registered head-valid flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      entry0_r <= '0;
      entry1_r <= '0;
      count_r  <= 2'd0;
      valid_r  <= 1'b0;
    end else begin
      entry0_r <= entry0_next_s;
      entry1_r <= entry1_next_s;
      count_r  <= count_next_s;
      valid_r  <= (count_next_s != 2'd0);
    end
  end

  assign count      = count_r;
  assign head_valid = valid_r;
  assign head       = entry0_r;

endmodule : fetch_buf2

// File: rtl/imem_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// imem_fetch_ctrl
// Instruction-fetch sequencer for the imem32 ROM. Owns the byte PC, drives the
// ROM word address, captures {pc, instr} into a 2-entry buffer and hands the
// head to decode over valid/ready. A redirect from execute flushes the buffer
// and reloads the PC.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   fetch_en     : level; high = keep fetching, low = stop issuing fetches
//   bus          : imem_fetch_ctrl_if.master (ROM, redirect, decode handshake)
//   misalign_err : sticky; a redirect target had nonzero low bits
//   halted       : high while halted on EBREAK (optional feature, else 0)
// Build option:
//   IFETCH_EBREAK_HALT_EN - when defined, fetching an EBREAK enters HALT, which
//   only a redirect or reset leaves. When undefined EBREAK is an ordinary
//   instruction and halted is tied low.
// The buffered entry type is sized from imem_pkg, so ADDR_WIDTH and
// INSTR_LENGTH must match the package defaults.
// -----------------------------------------------------------------------------
module imem_fetch_ctrl
  import imem_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int INSTR_LENGTH = DEF_INSTR_LENGTH,
  parameter int RESET_PC     = 0,
  parameter int BUF_DEPTH    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fetch_en,
  imem_fetch_ctrl_if.master   bus,
  output logic                misalign_err,
  output logic                halted
);

  localparam int PC_W = ADDR_WIDTH + 2;
  localparam logic [PC_W-1:0] RESET_PC_V = PC_W'(RESET_PC);
  localparam logic [PC_W-1:0] PC_STEP    = PC_W'(32'd4);

  // Unsupported configurations are rejected at elaboration.
  if ((ADDR_WIDTH != DEF_ADDR_WIDTH) || (INSTR_LENGTH != DEF_INSTR_LENGTH) ||
      (BUF_DEPTH != 2) || ((RESET_PC % 4) != 0)) begin : g_bad_cfg
    $error("imem_fetch_ctrl: unsupported parameter set");
  end

  fetch_state_t    state_r, state_next_s;
  logic [PC_W-1:0] pc_r;
  logic [PC_W-1:0] redirect_aligned_s;
  logic            misalign_r;
  logic            push_s, pop_s;
  logic            ebreak_push_s;
  logic [1:0]      count_s;
  logic            head_valid_s;
  fetch_entry_t    head_s, push_entry_s;

  assign redirect_aligned_s = {bus.redirect_pc[PC_W-1:2], 2'b00};
  assign bus.imem_addr      = pc_r[PC_W-1:2];

  // Entry captured on a push: current PC with the instruction the ROM returns.
  always_comb begin
    push_entry_s       = '0;
    push_entry_s.pc    = pc_r;
    push_entry_s.instr = bus.imem_instr;
  end

`ifdef IFETCH_EBREAK_HALT_EN
  logic halted_r;

  // FSM state register plus registered halt indicator.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      halted_r <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      halted_r <= (state_next_s == HALT);
    end
  end

  assign ebreak_push_s = push_s && (bus.imem_instr == EBREAK_INSTR);
  assign halted        = halted_r;
`else
  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  assign ebreak_push_s = 1'b0;
  assign halted        = 1'b0;
`endif

  // FSM next-state; a redirect never moves IDLE, and is the only way out of HALT.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.redirect_valid) begin
          state_next_s = IDLE;
        end else if (fetch_en) begin
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (!fetch_en) begin
          state_next_s = IDLE;
        end else if (ebreak_push_s) begin
          state_next_s = HALT;
        end else begin
          state_next_s = RUN;
        end
      end
`ifdef IFETCH_EBREAK_HALT_EN
      HALT: begin
        if (bus.redirect_valid) begin
          state_next_s = fetch_en ? RUN : IDLE;
        end else begin
          state_next_s = HALT;
        end
      end
`endif
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // FSM outputs: buffer push/pop strobes. A redirect cancels both.
  always_comb begin
    push_s = 1'b0;
    pop_s  = 1'b0;
    if (bus.redirect_valid) begin
      push_s = 1'b0;
      pop_s  = 1'b0;
    end else begin
      pop_s = head_valid_s && bus.out_ready;
      if ((state_r == RUN) && fetch_en &&
          ((count_s != 2'd2) || (head_valid_s && bus.out_ready))) begin
        push_s = 1'b1;
      end else begin
        push_s = 1'b0;
      end
    end
  end

  // Program counter: redirect wins, otherwise advance by one word per push.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r <= RESET_PC_V;
    end else if (bus.redirect_valid) begin
      pc_r <= redirect_aligned_s;
    end else if (push_s) begin
      pc_r <= pc_r + PC_STEP;
    end else begin
      pc_r <= pc_r;
    end
  end

  // Sticky misaligned-redirect flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_r <= 1'b0;
    end else if (bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00)) begin
      misalign_r <= 1'b1;
    end else begin
      misalign_r <= misalign_r;
    end
  end

  assign misalign_err = misalign_r;

  fetch_buf2 u_buf (
    .clk        (clk),
    .rst        (rst),
    .flush      (bus.redirect_valid),
    .push       (push_s),
    .pop        (pop_s),
    .push_entry (push_entry_s),
    .count      (count_s),
    .head_valid (head_valid_s),
    .head       (head_s)
  );

  assign bus.out_valid = head_valid_s;
  assign bus.out_pc    = head_s.pc;
  assign bus.out_instr = head_s.instr;

endmodule : imem_fetch_ctrl

// File: tb/tb_imem_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_imem_fetch_ctrl
// Directed bench for imem_fetch_ctrl with a behavioural imem32 ROM. Expected
// values are hand-derived from the ROM contents and the fetch timing.
// -----------------------------------------------------------------------------
module tb_imem_fetch_ctrl;

  logic clk;
  logic rst;
  logic fetch_en;
  logic misalign_err;
  logic halted;

  logic [31:0] rom [0:31];

  int n_cmp = 0;
  int n_err = 0;

  imem_fetch_ctrl_if #(.ADDR_WIDTH(5), .INSTR_LENGTH(32)) bus ();

  imem_fetch_ctrl #(
    .ADDR_WIDTH   (5),
    .INSTR_LENGTH (32),
    .RESET_PC     (0),
    .BUF_DEPTH    (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_en     (fetch_en),
    .bus          (bus),
    .misalign_err (misalign_err),
    .halted       (halted)
  );

  assign bus.imem_instr = rom[bus.imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc, input logic [31:0] instr);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_pc"}, 32'(bus.out_pc), pc);
    check({tag, "_instr"}, bus.out_instr, instr);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = {16'hA5A5, 8'(i), 8'h13};
    rom[0] = 32'h0000_0193;
    rom[1] = 32'h0010_0213;
    rom[2] = 32'h0020_0293;
    rom[3] = 32'h0050_01B3;
    rom[4] = 32'h0000_0013;
    rom[5] = 32'h0010_0073;

    rst = 1'b1; fetch_en = 1'b0;
    bus.out_ready = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = 7'h00;
    tick(); tick();

    // Reset state
    check("rst_valid",    32'(bus.out_valid), 32'd0);
    check("rst_pc",       32'(bus.out_pc), 32'd0);
    check("rst_instr",    bus.out_instr, 32'd0);
    check("rst_misalign", 32'(misalign_err), 32'd0);
    check("rst_halted",   32'(halted), 32'd0);
    check("rst_addr",     32'(bus.imem_addr), 32'd0);

    // Streaming fetch: fetch_en at cycle 0, first valid at cycle 2
    rst = 1'b0; fetch_en = 1'b1; bus.out_ready = 1'b1;
    tick();
    check("lat_c1_valid", 32'(bus.out_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_head("stream", 32'(4 * k), rom[k]);
    end

    // Back-pressure: head holds, pc stops at 0x08, then gapless delivery
    rst = 1'b1; tick();
    rst = 1'b0; bus.out_ready = 1'b0;
    tick(); tick();
    check_head("bp_first", 32'h00, 32'h0000_0193);
    for (int k = 0; k < 5; k++) begin
      tick();
      check_head("bp_hold", 32'h00, 32'h0000_0193);
    end
    check("bp_addr", 32'(bus.imem_addr), 32'd2);
    bus.out_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      tick();
      check_head("bp_drain", 32'(4 * k), rom[k]);
    end

    // Redirect while holding two entries
    rst = 1'b1; tick();
    rst = 1'b0; bus.out_ready = 1'b0;
    tick(); tick(); tick();
    check_head("rd_full", 32'h00, 32'h0000_0193);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 7'h0C; bus.out_ready = 1'b1;
    tick();
    bus.redirect_valid = 1'b0;
    check("rd_flush_valid", 32'(bus.out_valid), 32'd0);
    check("rd_addr", 32'(bus.imem_addr), 32'd3);
    tick();
    check_head("rd_new", 32'h0C, 32'h0050_01B3);
    tick();
    check_head("rd_next", 32'h10, 32'h0000_0013);

    // Misaligned redirect: low bits dropped, sticky error
    bus.redirect_valid = 1'b1; bus.redirect_pc = 7'h0E;
    tick();
    bus.redirect_valid = 1'b0;
    check("mis_addr", 32'(bus.imem_addr), 32'd3);
    check("mis_err", 32'(misalign_err), 32'd1);
    check("mis_flush", 32'(bus.out_valid), 32'd0);
    fetch_en = 1'b0;
    tick(); tick(); tick();
    check("mis_sticky", 32'(misalign_err), 32'd1);
    check("idle_drained", 32'(bus.out_valid), 32'd0);

    // Redirect in IDLE moves pc only; no fetch follows
    bus.redirect_valid = 1'b1; bus.redirect_pc = 7'h7C;
    tick();
    bus.redirect_valid = 1'b0;
    check("idle_rd_addr", 32'(bus.imem_addr), 32'd31);
    tick();
    check("idle_no_fetch_addr", 32'(bus.imem_addr), 32'd31);
    check("idle_no_fetch_valid", 32'(bus.out_valid), 32'd0);

    // PC wrap from 0x7C to 0x00
    fetch_en = 1'b1;
    tick(); tick();
    check("wrap_addr", 32'(bus.imem_addr), 32'd0);
    check_head("wrap_last", 32'h7C, rom[31]);
    tick();
    check_head("wrap_first", 32'h00, 32'h0000_0193);
    check("wrap_mis_sticky", 32'(misalign_err), 32'd1);

    // Reset clears the sticky error
    rst = 1'b1; tick();
    check("rst2_misalign", 32'(misalign_err), 32'd0);
    check("rst2_valid", 32'(bus.out_valid), 32'd0);
    rst = 1'b0;

    // EBREAK at word 5 (redirect in IDLE, then IDLE -> RUN, then fetch)
    bus.redirect_valid = 1'b1; bus.redirect_pc = 7'h14;
    tick();
    bus.redirect_valid = 1'b0;
    tick(); tick();
    check_head("ebreak", 32'h14, 32'h0010_0073);
`ifdef IFETCH_EBREAK_HALT_EN
    check("halt_on", 32'(halted), 32'd1);
    check("halt_addr", 32'(bus.imem_addr), 32'd6);
    tick(); tick();
    check("halt_hold_addr", 32'(bus.imem_addr), 32'd6);
    check("halt_drained", 32'(bus.out_valid), 32'd0);
    check("halt_still", 32'(halted), 32'd1);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 7'h00;
    tick();
    bus.redirect_valid = 1'b0;
    check("halt_exit", 32'(halted), 32'd0);
    check("halt_exit_addr", 32'(bus.imem_addr), 32'd0);
    tick();
    check_head("halt_resume", 32'h00, 32'h0000_0193);
`else
    check("no_halt", 32'(halted), 32'd0);
    tick();
    check_head("ebreak_next", 32'h18, rom[6]);
    check("no_halt_after", 32'(halted), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_imem_fetch_ctrl
